servant_uart_tx: RTL and testbench
==================================

// Module: servant_uart_tx
// PURPOSE
//  Wishbone-slave UART transmitter with a byte FIFO, for the servant SoC. It takes over serial output from the
//  bit-banged GPIO `q` line. The CPU posts bytes without busy-waiting. The block sequences start, data and
//  stop bits at a fixed baud divisor.
//  o_tx drives the line monitored by the bench uart_decoder.
// PARAMETERS
//  DIVISOR  280  clock cycles per serial bit. 280 gives ~57600 baud at the 16.13 MHz sim clock. Legal range >=2.
//  DEPTH    8    FIFO depth in bytes. Must be a power of 2, 2..128.
// PORTS
//  wb_clk     in   1   system clock, rising edge
//  wb_rst_n   in   1   asynchronous, active-low reset
//  i_wb_adr   in   1   register select: 0=DATA/STATUS, 1=CTRL
//  i_wb_dat   in   32  write data
//  i_wb_we    in   1   write enable
//  i_wb_cyc   in   1   bus cycle request
//  o_wb_rdt   out  32  read data
//  o_wb_ack   out  1   single-cycle acknowledge
//  o_tx       out  1   serial output, idle high
//  o_irq      out  1   level interrupt: transmitter drained
// BEHAVIOUR
//  Reset state, applied immediately on wb_rst_n=0:
//   - Outputs: o_tx=1, o_wb_ack=0, o_wb_rdt=0, o_irq=0.
//   - Internal: FIFO empty, CTRL=0, overflow=0, FSM=IDLE, baud counter=0.
//   - Reset mid-frame aborts the frame and flushes the FIFO.
//  Bus:
//   - o_wb_ack rises on the edge after i_wb_cyc is seen high with o_wb_ack low.
//   - o_wb_ack falls on the following edge, so there is one access per two cycles.
//   - All register side effects occur on the edge that sets o_wb_ack. o_wb_rdt is valid in that same ack cycle.
//  Write adr0: push i_wb_dat[7:0] into the FIFO.
//   - If the FIFO is full, the byte is dropped and overflow is set (sticky).
//  Write adr1: CTRL[0] = irq_en. Other bits are ignored.
//  Read adr0 (STATUS):
//   - Fields: [0] busy (FSM!=IDLE), [1] full, [2] empty, [3] overflow, [15:8] FIFO level, other bits 0.
//   - The read clears overflow after returning it. If an overflow occurs on the same edge, it stays set.
//  Read adr1: {31'b0, irq_en}.
//  FIFO:
//   - Circular buffer with log2(DEPTH)-bit pointers that wrap modulo DEPTH.
//   - Level is log2(DEPTH)+1 bits, range 0..DEPTH.
//   - Simultaneous push and pop on a full FIFO is not a push-when-full. Push is evaluated after pop, so the
//     byte is accepted and the level is unchanged.
//   - Simultaneous push and pop on an empty FIFO is impossible, because pop requires a non-empty FIFO.
//  TX FSM: IDLE -> START -> DATA -> STOP.
//   - Bit timing: each state bit lasts exactly DIVISOR cycles. The baud counter loads DIVISOR-1 and counts to 0.
//   - IDLE: o_tx=1. If the FIFO is non-empty, pop into the shift register and go to START.
//     Latency: o_tx falls on the 2nd rising edge after the edge setting o_wb_ack of a write to an empty, idle block.
//   - START: o_tx=0 -> DATA.
//   - DATA: o_tx=shift[0], LSB first. Shift right per bit and keep a 3-bit index. After bit 7 -> STOP.
//   - STOP: o_tx=1. At its end, pop and go to START if the FIFO is non-empty (no idle gap); else go to IDLE.
//   - One frame is exactly 10*DIVISOR cycles.
//  o_irq is registered: irq_en & empty & (FSM==IDLE). It deasserts one cycle after a push or after irq_en is cleared.
// TESTING
//  1. Reset: hold wb_rst_n=0 -> o_tx=1, o_irq=0, o_wb_ack=0. STATUS read after release -> 0x00000004.
//  2. DIVISOR=4, write 0x55 ->
//     - o_tx low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high.
//     - Frame spans 40 cycles and starts 2 edges after ack.
//  3. DIVISOR=4, write 0x41,0x42,0x43 back-to-back ->
//     - 120 contiguous frame cycles with stop bits not stretched.
//     - STATUS busy=1 during the frames; busy=0 and empty=1 afterwards.
//  4. DEPTH=4, DIVISOR=16, write 6 bytes quickly ->
//     - Byte 1 is popped immediately, bytes 2-5 fill the FIFO, byte 6 is dropped.
//     - STATUS reads 0x040B (level=4, overflow, full, busy); a 2nd read shows overflow=0.
//     - Line carries exactly 5 frames.
//  5. Write CTRL=1 while idle -> o_irq=1. Push a byte -> o_irq=0 next cycle; it returns 1 once STOP completes.
//  6. Assert wb_rst_n=0 mid-DATA with 3 bytes queued -> o_tx=1 asynchronously. After release, no further frames
//     and STATUS=0x4.

Source files
------------

// File: rtl/servant_uart_tx.sv
// Wishbone-slave UART transmitter: byte FIFO feeding an 8N1 serializer at a fixed baud divisor.
// Two-cycle bus protocol: the ack edge performs the register side effect and presents read data.
module servant_uart_tx #(
    parameter int DIVISOR = 280,
    parameter int DEPTH   = 8
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic        i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_tx,
    output logic        o_irq
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIVISOR - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          overflow, irq_en;

    logic        access, push_req, push_ok, pop, empty, full, bit_end, busy;
    logic        rd_status, ovf_set;
    logic [31:0] status;
    logic        unused_bits;

    assign unused_bits = ^i_wb_dat[31:8];

    // A new access is accepted only while ack is low, giving one access per two cycles.
    assign access    = i_wb_cyc & ~o_wb_ack;
    assign push_req  = access & i_wb_we & ~i_wb_adr;
    assign rd_status = access & ~i_wb_we & ~i_wb_adr;
    assign empty     = (level == '0);
    assign full      = (level == LVL_FULL);
    assign bit_end   = (cnt == '0);
    assign busy      = (state != S_IDLE);
    // Push is judged after a same-edge pop, so a full FIFO being drained still accepts.
    assign push_ok   = push_req & (~full | pop);
    assign ovf_set   = push_req & full & ~pop;
    assign status    = {16'h0, 8'(level), 4'h0, overflow, empty, full, busy};

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: if (bit_end) state_n = S_DATA;
            S_DATA:  if (bit_end && bit_idx == 3'd7) state_n = S_STOP;
            S_STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            o_tx    <= 1'b1;
            o_irq   <= 1'b0;
        end else begin
            state <= state_n;
            // Counter sits at its reload value while idle so every bit lasts DIVISOR cycles.
            if (state == S_IDLE || bit_end) cnt <= CNT_LOAD;
            else                            cnt <= cnt - 1'b1;
            if (pop) begin
                shift   <= mem[rd_ptr];
                bit_idx <= '0;
            end else if (state == S_DATA && bit_end) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 3'd1;
            end
            case (state)
                S_START: o_tx <= 1'b0;
                S_DATA:  o_tx <= shift[0];
                default: o_tx <= 1'b1;
            endcase
            o_irq <= irq_en & empty & (state == S_IDLE);
        end
    end

    always_ff @(posedge wb_clk) begin
        if (push_ok) mem[wr_ptr] <= i_wb_dat[7:0];
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            level    <= level + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
            // Status read clears overflow, but a same-edge overflow wins.
            overflow <= (overflow & ~rd_status) | ovf_set;
            if (access && i_wb_we && i_wb_adr) irq_en <= i_wb_dat[0];
            o_wb_ack <= access;
            if (access && !i_wb_we) o_wb_rdt <= i_wb_adr ? {31'h0, irq_en} : status;
            else                    o_wb_rdt <= '0;
        end
    end
endmodule

// File: tb/tb_servant_uart_tx.sv
// Bench for servant_uart_tx: two instances (DIV=4/DEPTH=8 and DIV=16/DEPTH=4) with a serial
// line decoder per instance checking decoded bytes against queues of expected bytes.
module tb_servant_uart_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cyc = '0, we = '0, adr = '0;
    logic [31:0] dat [2];
    logic [31:0] rdt [2];
    logic [1:0]  ack, tx, irq;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    int last_ack = 0;
    int frames [2];
    logic [1:0] mon_en = 2'b11;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int start_q0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    servant_uart_tx #(.DIVISOR(4), .DEPTH(8)) dut0 (
        .wb_clk(clk), .wb_rst_n(rst_n), .i_wb_adr(adr[0]), .i_wb_dat(dat[0]),
        .i_wb_we(we[0]), .i_wb_cyc(cyc[0]), .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]),
        .o_tx(tx[0]), .o_irq(irq[0]));

    servant_uart_tx #(.DIVISOR(16), .DEPTH(4)) dut1 (
        .wb_clk(clk), .wb_rst_n(rst_n), .i_wb_adr(adr[1]), .i_wb_dat(dat[1]),
        .i_wb_we(we[1]), .i_wb_cyc(cyc[1]), .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]),
        .o_tx(tx[1]), .o_irq(irq[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc_cnt < target) tick(1);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge on which ack falls.
    task automatic bus_op(input int u, input logic w, input logic a, input logic [31:0] d,
                          output logic [31:0] r);
        bit got = 0;
        cyc[u] = 1'b1; we[u] = w; adr[u] = a; dat[u] = d;
        for (int i = 0; i < 4 && !got; i++) begin
            tick(1);
            if (ack[u] === 1'b1) got = 1;
        end
        check("bus_ack_rise", {31'h0, got}, 32'h1);
        r = rdt[u];
        last_ack = cyc_cnt;
        cyc[u] = 1'b0; we[u] = 1'b0;
        tick(1);
        check("bus_ack_fall", {31'h0, ack[u]}, 32'h0);
    endtask

    task automatic wr(input int u, input logic a, input logic [31:0] d);
        logic [31:0] r;
        bus_op(u, 1'b1, a, d, r);
    endtask

    task automatic rd_check(input int u, input logic a, input logic [31:0] exp, input string name);
        logic [31:0] r;
        bus_op(u, 1'b0, a, 32'h0, r);
        check(name, r, exp);
    endtask

    task automatic push_byte(input int u, input logic [7:0] b);
        if (mon_en[u]) begin
            if (u == 0) exp_q0.push_back(b);
            else        exp_q1.push_back(b);
        end
        wr(u, 1'b0, {24'h0, b});
    endtask

    // Line decoder: samples mid-bit on falling clock edges, reconstructs 8N1 frames.
    task automatic decode_loop(input int u, input int div);
        int         start;
        logic [7:0] b;
        logic       start_ok, stop_ok;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx[u] === 1'b0) begin
                start = cyc_cnt;
                repeat (div / 2) @(negedge clk);
                start_ok = (tx[u] === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (div) @(negedge clk);
                    b[i] = tx[u];
                end
                repeat (div) @(negedge clk);
                stop_ok = (tx[u] === 1'b1);
                if (mon_en[u]) begin
                    frames[u]++;
                    if (u == 0) start_q0.push_back(start);
                    check("line_framing", {30'h0, start_ok, stop_ok}, 32'h3);
                    if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
                        check("line_unexpected_frame", {24'h0, b}, 32'hFFFFFFFF);
                    end else begin
                        e = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check("line_byte", {24'h0, b}, {24'h0, e});
                    end
                end
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic        adr;
        logic [31:0] dat;
        logic        chk_rdt;
        logic [31:0] exp_rdt;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [9];

    initial begin
        fork
            decode_loop(0, 4);
            decode_loop(1, 16);
        join_none
    end

    initial begin
        logic [31:0] r;
        int errs, ack0, n, zeros;
        logic [7:0] b;
        frames[0] = 0; frames[1] = 0;
        dat[0] = '0; dat[1] = '0;

        vecs[0] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h4, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0,        1'b1, 32'h0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h1,        1'b0, 32'h0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 32'h0,        1'b1, 32'h1, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h0,        1'b1, 32'h0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h3,        1'b0, 32'h0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h4, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 32'h0,        1'b0, 32'h0, 1'b0};

        // Reset state
        tick(3);
        for (int u = 0; u < 2; u++) begin
            check("rst_tx", {31'h0, tx[u]}, 32'h1);
            check("rst_irq", {31'h0, irq[u]}, 32'h0);
            check("rst_ack", {31'h0, ack[u]}, 32'h0);
            check("rst_rdt", rdt[u], 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // Register access table
        for (int i = 0; i < 9; i++) begin
            bus_op(0, vecs[i].we, vecs[i].adr, vecs[i].dat, r);
            if (vecs[i].chk_rdt) check("tbl_rdt", r, vecs[i].exp_rdt);
            check("tbl_irq", {31'h0, irq[0]}, {31'h0, vecs[i].exp_irq});
        end

        // Single frame waveform: 0x55 with DIVISOR=4
        start_q0.delete();
        push_byte(0, 8'h55);
        ack0 = last_ack;
        errs = 0;
        for (int k = 1; k <= 42; k++) begin
            int idx, slot;
            logic e;
            wait_until(ack0 + k);
            idx = k - 2;
            if (idx < 0 || idx >= 40) e = 1'b1;
            else begin
                slot = idx / 4;
                if (slot == 0)      e = 1'b0;
                else if (slot == 9) e = 1'b1;
                else                e = ((8'h55 >> (slot - 1)) & 8'h1) != 0;
            end
            if (tx[0] !== e) errs++;
        end
        check("t2_wave_errors", errs, 0);
        tick(4);
        check("t2_frames", start_q0.size(), 1);
        if (start_q0.size() > 0) check("t2_start_latency", start_q0[0] - ack0, 2);

        // Three back-to-back bytes
        start_q0.delete();
        push_byte(0, 8'h41);
        ack0 = last_ack;
        push_byte(0, 8'h42);
        push_byte(0, 8'h43);
        rd_check(0, 1'b0, 32'h0000_0201, "t3_status_busy");
        wait_until(ack0 + 130);
        check("t3_frames", start_q0.size(), 3);
        if (start_q0.size() == 3) begin
            check("t3_first_start", start_q0[0] - ack0, 2);
            check("t3_gap1", start_q0[1] - start_q0[0], 40);
            check("t3_gap2", start_q0[2] - start_q0[1], 40);
        end
        rd_check(0, 1'b0, 32'h4, "t3_status_idle");

        // Randomized bursts against the expected-byte queue
        for (int rnd = 0; rnd < 5; rnd++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom_range(0, 255));
                push_byte(0, b);
                tick($urandom_range(0, 3));
            end
            tick(n * 40 + 20);
            check("rnd_drained", exp_q0.size(), 0);
            rd_check(0, 1'b0, 32'h4, "rnd_status_idle");
        end

        // Overflow with DEPTH=4, DIVISOR=16
        for (int i = 0; i < 6; i++) begin
            if (i < 5) push_byte(1, 8'(8'hA0 + i));
            else       wr(1, 1'b0, 32'h0000_00FF);
        end
        rd_check(1, 1'b0, 32'h0000_040B, "t4_status_ovf");
        rd_check(1, 1'b0, 32'h0000_0403, "t4_status_ovf_clear");
        tick(5 * 160 + 200);
        check("t4_frames", frames[1], 5);
        check("t4_drained", exp_q1.size(), 0);
        rd_check(1, 1'b0, 32'h4, "t4_status_idle");

        // Interrupt behaviour
        wr(0, 1'b1, 32'h1);
        check("t5_irq_idle", {31'h0, irq[0]}, 32'h1);
        push_byte(0, 8'hA5);
        ack0 = last_ack;
        check("t5_irq_push", {31'h0, irq[0]}, 32'h0);
        wait_until(ack0 + 20);
        check("t5_irq_frame", {31'h0, irq[0]}, 32'h0);
        wait_until(ack0 + 44);
        check("t5_irq_done", {31'h0, irq[0]}, 32'h1);
        check("t5_drained", exp_q0.size(), 0);

        // Reset in mid-frame with bytes queued
        mon_en[0] = 1'b0;
        wr(0, 1'b0, 32'h0);
        ack0 = last_ack;
        for (int i = 0; i < 3; i++) wr(0, 1'b0, 32'h0);
        wait_until(ack0 + 16);
        check("t6_tx_data_low", {31'h0, tx[0]}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_tx_async", {31'h0, tx[0]}, 32'h1);
        check("t6_irq", {31'h0, irq[0]}, 32'h0);
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        zeros = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (tx[0] !== 1'b1) zeros++;
        end
        check("t6_no_frames", zeros, 0);
        rd_check(0, 1'b0, 32'h4, "t6_status");
        rd_check(0, 1'b1, 32'h0, "t6_ctrl");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
